// File: rtl/riscv_i32_ifetch_sram_responder_pkg.sv
// Shared constants and small helpers for the instruction-fetch SRAM responder.
// Only encodings and pure functions live here; no state.
package riscv_i32_ifetch_sram_responder_pkg;

    localparam int REQ_TYPE_W = 3;
    localparam int MODE_W     = 3;
    localparam int TAG_W      = 2;

    localparam logic [REQ_TYPE_W-1:0] REQ_TYPE_NONE = 3'd0;
    localparam logic [TAG_W-1:0]      RESP_TAG      = 2'b00;

    // True when the byte address falls inside the SRAM window starting at base.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int          sram_addr_width
    );
        return (addr >> (sram_addr_width + 2)) == (base >> (sram_addr_width + 2));
    endfunction

    function automatic logic [31:0] merge_halves(
        input logic [31:0] hi_word,
        input logic [31:0] lo_word
    );
        return {hi_word[15:0], lo_word[31:16]};
    endfunction

endpackage

// File: rtl/riscv_i32_ifetch_sram_responder_if.sv
// Instruction-fetch request/response bundle between the core (master) and
// the memory-side responder (slave).
interface riscv_i32_ifetch_sram_responder_if;
    import riscv_i32_ifetch_sram_responder_pkg::*;

    logic                  ifetch_req__flush_pipeline;
    logic [REQ_TYPE_W-1:0] ifetch_req__req_type;
    logic                  ifetch_req__debug_fetch;
    logic [31:0]           ifetch_req__address;
    logic [MODE_W-1:0]     ifetch_req__mode;
    logic                  ifetch_req__predicted_branch;
    logic [31:0]           ifetch_req__pc_if_mispredicted;

    logic                  ifetch_resp__valid;
    logic                  ifetch_resp__debug;
    logic [31:0]           ifetch_resp__data;
    logic [MODE_W-1:0]     ifetch_resp__mode;
    logic                  ifetch_resp__error;
    logic [TAG_W-1:0]      ifetch_resp__tag;

    modport master (
        output ifetch_req__flush_pipeline, ifetch_req__req_type, ifetch_req__debug_fetch,
               ifetch_req__address, ifetch_req__mode, ifetch_req__predicted_branch,
               ifetch_req__pc_if_mispredicted,
        input  ifetch_resp__valid, ifetch_resp__debug, ifetch_resp__data,
               ifetch_resp__mode, ifetch_resp__error, ifetch_resp__tag
    );

    modport slave (
        input  ifetch_req__flush_pipeline, ifetch_req__req_type, ifetch_req__debug_fetch,
               ifetch_req__address, ifetch_req__mode, ifetch_req__predicted_branch,
               ifetch_req__pc_if_mispredicted,
        output ifetch_resp__valid, ifetch_resp__debug, ifetch_resp__data,
               ifetch_resp__mode, ifetch_resp__error, ifetch_resp__tag
    );

endinterface

// File: rtl/riscv_i32_ifetch_sram_responder.sv
// Ifetch responder: reads a synchronous single-port SRAM and returns 32 bits
// aligned to bit 0 for any halfword address, with a one-word line buffer.
module riscv_i32_ifetch_sram_responder
    import riscv_i32_ifetch_sram_responder_pkg::*;
#(
    parameter int          SRAM_ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDRESS    = 32'h0
) (
    input  logic                             clk,
    input  logic                             reset,
    riscv_i32_ifetch_sram_responder_if.slave ifetch,
    input  logic                             buffer_invalidate,
    output logic                             sram_read_enable,
    output logic [SRAM_ADDR_WIDTH-1:0]       sram_address,
    input  logic [31:0]                      sram_read_data
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RD_ALIGNED = 3'd1,
        ST_RD_LO      = 3'd2,
        ST_RD_HI      = 3'd3,
        ST_RESP_ERR   = 3'd4,
        ST_RESP_DBG   = 3'd5
    } state_t;

    localparam logic [SRAM_ADDR_WIDTH-1:0] IDX_ONE  = {{(SRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SRAM_ADDR_WIDTH-1:0] IDX_LAST = {SRAM_ADDR_WIDTH{1'b1}};
    localparam logic [SRAM_ADDR_WIDTH-1:0] IDX_ZERO = {SRAM_ADDR_WIDTH{1'b0}};

    state_t                     state_r;
    // Index of the SRAM word whose data arrives in the current read state.
    logic [SRAM_ADDR_WIDTH-1:0] rd_idx_r;
    logic                       buf_valid_r;
    logic [SRAM_ADDR_WIDTH-1:0] buf_idx_r;
    logic [31:0]                buf_data_r;

    logic [SRAM_ADDR_WIDTH-1:0] req_word_s;
    logic                       req_accept_s;
    logic                       buf_hit_s;
    state_t                     idle_next_s;
    logic                       idle_read_s;
    logic [SRAM_ADDR_WIDTH-1:0] idle_rd_idx_s;
    logic                       buf_load_s;
    logic                       resp_ok_s;
    logic                       valid_s;
    logic                       err_s;
    logic                       dbg_s;
    logic [31:0]                data_s;
    logic                       unused_inputs_s;

    assign unused_inputs_s = ^{ifetch.ifetch_req__predicted_branch,
                               ifetch.ifetch_req__pc_if_mispredicted,
                               ifetch.ifetch_req__address[0]};

    // Decode the request presented in IDLE into next state and first SRAM read.
    always_comb begin
        req_word_s    = ifetch.ifetch_req__address[SRAM_ADDR_WIDTH+1:2];
        req_accept_s  = (ifetch.ifetch_req__req_type != REQ_TYPE_NONE) &&
                        !ifetch.ifetch_req__flush_pipeline && !reset;
        buf_hit_s     = buf_valid_r && (buf_idx_r == req_word_s);
        idle_next_s   = ST_IDLE;
        idle_read_s   = 1'b0;
        idle_rd_idx_s = req_word_s;
        if (!req_accept_s) begin
            idle_next_s = ST_IDLE;
        end else if (ifetch.ifetch_req__debug_fetch) begin
            idle_next_s = ST_RESP_DBG;
        end else if (!addr_in_range(ifetch.ifetch_req__address, BASE_ADDRESS, SRAM_ADDR_WIDTH)) begin
            idle_next_s = ST_RESP_ERR;
        end else if (ifetch.ifetch_req__address[1] && (req_word_s == IDX_LAST)) begin
            // The upper half would lie past the end of the SRAM; no wrap-around.
            idle_next_s = ST_RESP_ERR;
        end else if (!ifetch.ifetch_req__address[1]) begin
            idle_next_s = ST_RD_ALIGNED;
            idle_read_s = 1'b1;
        end else if (buf_hit_s) begin
            idle_next_s   = ST_RD_HI;
            idle_read_s   = 1'b1;
            idle_rd_idx_s = req_word_s + IDX_ONE;
        end else begin
            idle_next_s = ST_RD_LO;
            idle_read_s = 1'b1;
        end
    end

    // SRAM strobe and word address, combinational from state and request.
    always_comb begin
        sram_read_enable = 1'b0;
        sram_address     = IDX_ZERO;
        case (state_r)
            ST_IDLE: begin
                if (idle_read_s) begin
                    sram_read_enable = 1'b1;
                    sram_address     = idle_rd_idx_s;
                end else begin
                    sram_read_enable = 1'b0;
                end
            end
            ST_RD_LO: begin
                if (!ifetch.ifetch_req__flush_pipeline && !reset) begin
                    sram_read_enable = 1'b1;
                    sram_address     = rd_idx_r + IDX_ONE;
                end else begin
                    sram_read_enable = 1'b0;
                end
            end
            default: sram_read_enable = 1'b0;
        endcase
    end

    // Response formation; a flush or reset in the response cycle suppresses it.
    always_comb begin
        resp_ok_s  = !ifetch.ifetch_req__flush_pipeline && !reset;
        valid_s    = 1'b0;
        err_s      = 1'b0;
        dbg_s      = 1'b0;
        data_s     = 32'h0;
        buf_load_s = 1'b0;
        case (state_r)
            ST_RD_ALIGNED: begin
                valid_s    = resp_ok_s;
                data_s     = sram_read_data;
                buf_load_s = 1'b1;
            end
            ST_RD_LO: begin
                buf_load_s = 1'b1;
            end
            ST_RD_HI: begin
                valid_s    = resp_ok_s;
                data_s     = merge_halves(sram_read_data, buf_data_r);
                buf_load_s = 1'b1;
            end
            ST_RESP_ERR: begin
                valid_s = resp_ok_s;
                err_s   = 1'b1;
            end
            ST_RESP_DBG: begin
                valid_s = resp_ok_s;
                dbg_s   = 1'b1;
            end
            default: valid_s = 1'b0;
        endcase
    end

    assign ifetch.ifetch_resp__valid = valid_s;
    assign ifetch.ifetch_resp__data  = valid_s ? data_s : 32'h0;
    assign ifetch.ifetch_resp__error = valid_s & err_s;
    assign ifetch.ifetch_resp__debug = valid_s & dbg_s;
    assign ifetch.ifetch_resp__mode  = valid_s ? ifetch.ifetch_req__mode : 3'b000;
    assign ifetch.ifetch_resp__tag   = RESP_TAG;

    // Fetch FSM and line buffer; loads happen even under flush since the data is real.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rd_idx_r    <= IDX_ZERO;
            buf_valid_r <= 1'b0;
            buf_idx_r   <= IDX_ZERO;
            buf_data_r  <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r  <= idle_next_s;
                    rd_idx_r <= idle_rd_idx_s;
                end
                ST_RD_LO: begin
                    state_r  <= ifetch.ifetch_req__flush_pipeline ? ST_IDLE : ST_RD_HI;
                    rd_idx_r <= rd_idx_r + IDX_ONE;
                end
                default: state_r <= ST_IDLE;
            endcase
            if (buf_load_s) begin
                buf_idx_r  <= rd_idx_r;
                buf_data_r <= sram_read_data;
            end else begin
                buf_data_r <= buf_data_r;
            end
            if (buffer_invalidate) begin
                buf_valid_r <= 1'b0;
            end else if (buf_load_s) begin
                buf_valid_r <= 1'b1;
            end else begin
                buf_valid_r <= buf_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_riscv_i32_ifetch_sram_responder.sv
// Scoreboard bench for the ifetch SRAM responder: directed cases followed by
// randomized fetches checked against a word-array reference model.
module tb_riscv_i32_ifetch_sram_responder;

    localparam int          AW    = 14;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        dbg;
        logic [2:0]  mode;
        int          lat;
        int          reads;
        int          issue;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          buffer_invalidate;
    logic          sram_read_enable;
    logic [AW-1:0] sram_address;
    logic [31:0]   sram_read_data = 32'h0;

    riscv_i32_ifetch_sram_responder_if ifetch();

    riscv_i32_ifetch_sram_responder #(.SRAM_ADDR_WIDTH(AW), .BASE_ADDRESS(BASE)) dut (
        .clk               (clk),
        .reset             (reset),
        .ifetch            (ifetch),
        .buffer_invalidate (buffer_invalidate),
        .sram_read_enable  (sram_read_enable),
        .sram_address      (sram_address),
        .sram_read_data    (sram_read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [DEPTH];
    always @(posedge clk) if (sram_read_enable) sram_read_data <= mem[sram_address];

    int cycle = 0;
    always @(posedge clk) cycle++;

    exp_t sb[$];
    bit   rd_at[int];
    int   errors = 0;
    int   checks = 0;
    bit   mdl_valid = 1'b0;
    int   mdl_idx = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    // Reference: expected response for a fetch, updating the model line buffer.
    function automatic exp_t predict(logic [31:0] addr, bit dbg, logic [2:0] mode);
        exp_t        e;
        longint      a = addr;
        int          w;
        logic [31:0] lo;
        logic [31:0] hi;
        e.data = 32'h0; e.err = 1'b0; e.dbg = 1'b0; e.mode = mode;
        e.lat = 1; e.reads = 0; e.issue = 0;
        w = int'((a - longint'(BASE)) >>> 2) & (DEPTH - 1);
        if (dbg) begin
            e.dbg = 1'b1;
        end else if (a < longint'(BASE) || a >= longint'(BASE) + 4 * DEPTH) begin
            e.err = 1'b1;
        end else if (addr[1] && w == DEPTH - 1) begin
            e.err = 1'b1;
        end else if (!addr[1]) begin
            e.data = mem[w]; e.reads = 1;
            mdl_valid = 1'b1; mdl_idx = w;
        end else begin
            lo = mem[w]; hi = mem[w + 1];
            e.data = (hi << 16) | (lo >> 16);
            if (mdl_valid && mdl_idx == w) begin
                e.reads = 1; e.lat = 1;
            end else begin
                e.reads = 2; e.lat = 2;
            end
            mdl_valid = 1'b1; mdl_idx = w + 1;
        end
        return e;
    endfunction

    task automatic drive_req(logic [2:0] rtype, logic [31:0] addr, bit dbg, logic [2:0] mode);
        ifetch.ifetch_req__req_type            = rtype;
        ifetch.ifetch_req__address             = addr;
        ifetch.ifetch_req__debug_fetch         = dbg;
        ifetch.ifetch_req__mode                = mode;
        ifetch.ifetch_req__flush_pipeline      = 1'b0;
        ifetch.ifetch_req__predicted_branch    = 1'($urandom_range(0, 1));
        ifetch.ifetch_req__pc_if_mispredicted  = $urandom;
        buffer_invalidate                      = 1'b0;
    endtask

    task automatic do_fetch(logic [31:0] addr, bit dbg, logic [2:0] mode);
        exp_t e;
        bit   got = 1'b0;
        @(posedge clk); #1;
        e = predict(addr, dbg, mode);
        e.issue = cycle;
        sb.push_back(e);
        drive_req(3'($urandom_range(1, 7)), addr, dbg, mode);
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (ifetch.ifetch_resp__valid) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_timeout: no response for address %h", addr);
            if (sb.size() > 0) void'(sb.pop_back());
        end
    endtask

    task automatic idle(int n, bit inv);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ifetch.ifetch_req__req_type       = 3'd0;
            ifetch.ifetch_req__flush_pipeline = 1'b0;
            buffer_invalidate                 = inv && (i == 0);
        end
        if (inv) mdl_valid = 1'b0;
    endtask

    task automatic check_quiet(string name);
        chk({name, "_valid"}, 64'(ifetch.ifetch_resp__valid), 64'd0);
        chk({name, "_outs"}, {ifetch.ifetch_resp__data, ifetch.ifetch_resp__mode,
            ifetch.ifetch_resp__error, ifetch.ifetch_resp__debug, ifetch.ifetch_resp__tag},
            64'd0);
        chk({name, "_sram"}, {sram_read_enable, sram_address}, 64'd0);
    endtask

    // Monitor: pop and compare on every response outside reset.
    exp_t m_e;
    int   m_n;
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (sram_read_enable) rd_at[cycle] = 1'b1;
            if (ifetch.ifetch_resp__valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: data %h at cycle %0d",
                             ifetch.ifetch_resp__data, cycle);
                end else begin
                    m_e = sb.pop_front();
                    m_n = 0;
                    for (int c = m_e.issue; c <= cycle; c++) if (rd_at.exists(c)) m_n++;
                    chk("resp_data", 64'(ifetch.ifetch_resp__data), 64'(m_e.data));
                    chk("resp_error", 64'(ifetch.ifetch_resp__error), 64'(m_e.err));
                    chk("resp_debug", 64'(ifetch.ifetch_resp__debug), 64'(m_e.dbg));
                    chk("resp_mode", 64'(ifetch.ifetch_resp__mode), 64'(m_e.mode));
                    chk("resp_tag", 64'(ifetch.ifetch_resp__tag), 64'd0);
                    chk("resp_latency", 64'(cycle - m_e.issue), 64'(m_e.lat));
                    chk("sram_reads", 64'(m_n), 64'(m_e.reads));
                end
            end else begin
                chk("idle_resp_outs", {ifetch.ifetch_resp__data, ifetch.ifetch_resp__mode,
                    ifetch.ifetch_resp__error, ifetch.ifetch_resp__debug}, 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] addr;
    logic [31:0] last_addr;
    int          kind;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[4] = 32'h00500093;
        mem[0] = 32'h1111AAAA;
        mem[1] = 32'h3333BBBB;
        mem[2] = 32'h5555CCCC;

        reset = 1'b1;
        drive_req(3'd0, 32'h0, 1'b0, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_quiet("in_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");

        // Directed cases from the plan.
        do_fetch(32'h0000_0010, 1'b0, 3'd0);
        do_fetch(32'h0000_0002, 1'b0, 3'd1);
        do_fetch(32'h0000_0006, 1'b0, 3'd2);
        idle(1, 1'b1);
        do_fetch(32'h0000_000A, 1'b0, 3'd0);
        do_fetch(BASE + 32'h0001_0000, 1'b0, 3'd0);
        do_fetch(32'h0000_FFFE, 1'b0, 3'd0);
        do_fetch(32'h0000_FFFC, 1'b0, 3'd0);
        do_fetch(32'h0000_0040, 1'b1, 3'd3);

        // Flush during RD_LO: no response, buffer still holds the word read.
        idle(1, 1'b1);
        @(posedge clk); #1;
        drive_req(3'd1, 32'h0000_002A, 1'b0, 3'd0);
        @(posedge clk); #1;
        ifetch.ifetch_req__flush_pipeline = 1'b1;
        @(negedge clk);
        chk("flush_no_resp", 64'(ifetch.ifetch_resp__valid), 64'd0);
        @(posedge clk); #1;
        ifetch.ifetch_req__flush_pipeline = 1'b0;
        ifetch.ifetch_req__req_type       = 3'd0;
        mdl_valid = 1'b1; mdl_idx = 10;
        do_fetch(32'h0000_002A, 1'b0, 3'd0);
        do_fetch(32'h0000_0080, 1'b0, 3'd0);

        // Reset during RD_HI: quiet outputs next cycle and buffer lost.
        idle(1, 1'b1);
        @(posedge clk); #1;
        drive_req(3'd1, 32'h0000_0052, 1'b0, 3'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ifetch.ifetch_req__req_type = 3'd0;
        mdl_valid = 1'b0;
        @(negedge clk);
        check_quiet("post_reset_hi");
        do_fetch(32'h0000_0052, 1'b0, 3'd5);

        // Randomized fetches biased toward sequential compressed code.
        last_addr = 32'h0000_0100;
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3) addr = last_addr + 32'd2;
            else if (kind <= 5) addr = BASE + 32'($urandom_range(0, 255)) * 32'd2;
            else if (kind == 6) addr = BASE + 32'($urandom_range(0, DEPTH * 2 - 1)) * 32'd2;
            else if (kind == 7) addr = BASE + 32'(DEPTH * 4) - 32'($urandom_range(1, 3)) * 32'd2;
            else addr = {16'($urandom_range(1, 65535)), 16'($urandom)};
            if (kind <= 7) addr[0] = 1'($urandom_range(0, 1));
            do_fetch(addr, (kind == 9) || ($urandom_range(0, 19) == 0), 3'($urandom));
            last_addr = addr & 32'h0000_FFFE;
            if ($urandom_range(0, 3) == 0) idle(1, $urandom_range(0, 3) == 0);
        end

        idle(2, 1'b0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_i32_ifetch_sram_responder.md
# riscv_i32_ifetch_sram_responder

Memory-side responder for the instruction-fetch interface: accepts the core's ifetch request, reads a synchronous single-port instruction SRAM, and returns 32 bits of instruction data aligned to bit 0 for any 16-bit-aligned address. It is the counterpart of the pipeline's fetch-data path. It sits between the pipeline control and the instruction SRAM. A one-word line buffer avoids a second read on sequential misaligned fetches (compressed code).

## Interface
- SRAM_ADDR_WIDTH, 14, word-address width of the SRAM (2^14 x 32 = 64 KB)
- BASE_ADDRESS, 32'h0, byte base of the SRAM; must be aligned to 4<<SRAM_ADDR_WIDTH
- clk  in  1  clock, single domain
- reset  in  1  synchronous, active-high reset
- ifetch_req__flush_pipeline  in  1  abort any in-flight fetch
- ifetch_req__req_type  in  3  0 = none, any other value = fetch
- ifetch_req__debug_fetch  in  1  debug fetch; no SRAM access
- ifetch_req__address  in  32  byte address, bit 0 ignored
- ifetch_req__mode  in  3  privilege mode, echoed
- ifetch_req__predicted_branch, ifetch_req__pc_if_mispredicted  in  1/32  unused here
- buffer_invalidate  in  1  fence.i / external write; clears line buffer
- sram_read_enable  out  1  SRAM read strobe
- sram_address  out  SRAM_ADDR_WIDTH  SRAM word address
- sram_read_data  in  32  SRAM data, valid the cycle after read_enable
- ifetch_resp__valid  out  1  response valid
- ifetch_resp__debug  out  1  response to a debug fetch
- ifetch_resp__data  out  32  instruction bits, 0 when not valid
- ifetch_resp__mode  out  3  echo of ifetch_req__mode
- ifetch_resp__error  out  1  access fault
- ifetch_resp__tag  out  2  always 2'b00

## Operation
- Handshake: the requester holds ifetch_req stable from issue until the cycle ifetch_resp__valid=1. It may change the request in the following cycle. Exactly one response per accepted request.
- Word index w = address[SRAM_ADDR_WIDTH+1:2]. In range iff address[31:SRAM_ADDR_WIDTH+2] equals the matching bits of BASE_ADDRESS.
- States: IDLE, RD_ALIGNED, RD_LO, RD_HI, RESP_ERR, RESP_DBG.
- IDLE, req_type!=0, no flush:
  - debug_fetch -> RESP_DBG. No SRAM access.
  - Out of range -> RESP_ERR.
  - address[1]=1 and w = all-ones -> RESP_ERR, because the upper half crosses the SRAM end. No wrap.
  - address[1]=0 -> read w, go RD_ALIGNED.
  - address[1]=1, buffer valid and buf_idx==w -> read w+1, go RD_HI.
  - address[1]=1, otherwise -> read w, go RD_LO.
- RD_ALIGNED: valid=1, data=sram_read_data. Buffer <= (w, data). Go IDLE.
- RD_LO: buffer <= (w, sram_read_data). Read w+1. Go RD_HI.
- RD_HI: valid=1, data={sram_read_data[15:0], buffer[31:16]}. Buffer <= (w+1, sram_read_data). Go IDLE.
- RESP_ERR: valid=1, error=1, data=0. Go IDLE.
- RESP_DBG: valid=1, debug=1, data=0. Go IDLE.
- Flush in any non-IDLE state: go IDLE, no response. Data already read still loads the buffer, because it is correct memory content. Flush in IDLE: the request is ignored that cycle.
- buffer_invalidate: buffer valid <= 0 in that cycle. It has priority over a same-cycle buffer load.
- mode: echoed combinationally from ifetch_req__mode while valid, else 0.

## Timing
- Reset: state IDLE, buffer invalid, buf_idx 0. All response outputs are 0, sram_read_enable=0, sram_address=0.
- The SRAM outputs are combinational from state and request. The response outputs are combinational from registered state, the buffer and sram_read_data.
- Latency, request first presented in cycle N:
  - Aligned, error and debug fetches: response in N+1.
  - Misaligned with buffer hit: response in N+1.
  - Misaligned with buffer miss: response in N+2.
- Back-to-back: the next request is accepted the cycle after valid. Maximum throughput is one response per 2 cycles.
- Reset asserted mid-fetch: state returns to IDLE next edge, no response, buffer invalidated.

## Structure
- The ifetch request/response structures and the req_type encoding already live in the shared riscv package. No new shared typedefs are added.
- The state enum is local to the module.
- Single module. The line buffer (valid, idx, data) is inline registers, small enough not to justify a sub-module.

## Test plan
- Aligned fetch: SRAM word 4 = 32'h00500093, request at 0x10 -> read_enable with address 4 in N, resp valid data 32'h00500093 in N+1, error 0.
- Misaligned miss then hit:
  - Words 0 = 32'h1111AAAA and 1 = 32'h3333BBBB; request at 0x2 -> reads 0 then 1, resp at N+2 with data 32'hBBBB1111.
  - Then request at 0x6 with word 2 = 32'h5555CCCC -> single read of 2, resp at N+1 with data 32'hCCCC3333.
- Out of range: request at BASE+0x10000 (default SRAM_ADDR_WIDTH) -> no read_enable, resp N+1 with error=1, data 0. The last-halfword address 0xFFFE also gives an error.
- Flush during RD_LO -> no response. The next aligned request completes normally, and buffer holds the word read.
- buffer_invalidate between two sequential misaligned fetches -> second fetch takes 2 reads and N+2 latency.
- Debug fetch with mode 3 -> resp N+1 with debug=1, mode=3, data 0, no SRAM access. Reset mid-RD_HI -> all outputs 0 next cycle.
